// File: rtl/divisor_arb_pkg.sv
// Shared types and constants for the divisor_arbiter block.
package divisor_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ZCHK,
        START,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned MAX_W = 256;

    // Quotient returned for a zero divisor; sliced down to W at the use site.
    localparam logic [MAX_W-1:0] DIV_ZERO_Q = '1;

    // Index width for n items, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/divisor_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int unsigned j;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
        any = found;
    end

endmodule

// File: rtl/divisor_arbiter.sv
// Shares one divisor core among NREQ requesters with round-robin arbitration.
// Optional watchdog in WAIT when DIVARB_TIMEOUT_EN is defined.
module divisor_arbiter
    import divisor_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned W           = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_dv,
    input  logic [NREQ*W-1:0] req_dr,
    output logic [NREQ-1:0]   req_grant,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_result,
    output logic [W-1:0]      rsp_mod,
    output logic              rsp_err,
    output logic              busy,
    output logic [W-1:0]      div_dv,
    output logic [W-1:0]      div_dr,
    output logic              div_init,
    input  logic              div_ready,
    input  logic [W-1:0]      div_result,
    input  logic [W-1:0]      div_mod
);

    localparam int unsigned IW = clog2(NREQ);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic [NREQ-1:0] owner_hot;
    logic            arb_any;
    logic            ready_q;
    logic            ready_rise;
    logic [W-1:0]    sel_dv;
    logic [W-1:0]    sel_dr;

`ifdef DIVARB_TIMEOUT_EN
    localparam int unsigned TW = clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Grant is a Mealy pulse so operands are taken in the same cycle it is shown.
    always_comb begin
        req_grant = '0;
        if (state == IDLE && !rst) req_grant = arb_grant;
    end

    always_comb begin
        sel_dv = '0;
        sel_dr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_dv = req_dv[i*W +: W];
                sel_dr = req_dr[i*W +: W];
            end
        end
    end

    always_comb begin
        owner_hot  = NREQ'(1) << owner;
        ready_rise = div_ready & ~ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            div_dv     <= '0;
            div_dr     <= '0;
            div_init   <= 1'b0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_mod    <= '0;
            rsp_err    <= 1'b0;
`ifdef DIVARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            ready_q    <= div_ready;
            div_init   <= 1'b0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_mod    <= '0;
            rsp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        div_dv <= sel_dv;
                        div_dr <= sel_dr;
                        owner  <= arb_idx;
                        ptr    <= (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                        busy   <= 1'b1;
                        state  <= ZCHK;
                    end
                end
                ZCHK: begin
                    if (div_dr == '0) begin
                        rsp_valid  <= owner_hot;
                        rsp_result <= W'(DIV_ZERO_Q);
                        rsp_mod    <= div_dv;
                        rsp_err    <= 1'b1;
                        state      <= RESP;
                    end else begin
                        div_init <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
`ifdef DIVARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    // ready_q holds the START-cycle level, so a stale high ready never counts.
                    if (ready_rise) begin
                        rsp_valid  <= owner_hot;
                        rsp_result <= div_result;
                        rsp_mod    <= div_mod;
                        state      <= RESP;
                    end
`ifdef DIVARB_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        rsp_valid <= owner_hot;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
